// File: rtl/chunked_subtractor.sv
// Multi-cycle unsigned subtractor: a - b over WIDTH bits, CHUNK bits per clock, LSB chunk first,
// with an optional conditional-subtract mode that restores a when a < b.
module chunked_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cond_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cond_reg;
  logic             chain_reg;
  logic [IDX_W-1:0] index_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             borrow_reg;

  logic [CHUNK-1:0] a_chunk        [NCHUNK];
  logic [CHUNK-1:0] b_chunk        [NCHUNK];
  logic [CHUNK-1:0] diff_chunk_reg [NCHUNK];
  logic [CHUNK:0]   sub_next;

  // Operands and result are handled as chunk arrays so the active chunk is a plain index.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi]                  = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk[gi]                  = b_reg[gi*CHUNK +: CHUNK];
      assign diff[gi*CHUNK +: CHUNK]      = diff_chunk_reg[gi];
    end
  endgenerate

  // CHUNK+1 bit difference: the top bit is the borrow out of this chunk.
  always_comb begin
    sub_next = {1'b0, a_chunk[index_reg]}
             - {1'b0, b_chunk[index_reg]}
             - {{CHUNK{1'b0}}, chain_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      cond_reg   <= 1'b0;
      chain_reg  <= 1'b0;
      index_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      borrow_reg <= 1'b0;
      for (int i = 0; i < NCHUNK; i++) begin
        diff_chunk_reg[i] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The cycle carrying done still counts as the tail of the operation.
          if (start && !done_reg) begin
            a_reg     <= a;
            b_reg     <= b;
            cond_reg  <= cond_sub;
            chain_reg <= 1'b0;
            index_reg <= '0;
            busy_reg  <= 1'b1;
            for (int i = 0; i < NCHUNK; i++) begin
              diff_chunk_reg[i] <= '0;
            end
            state_reg <= RUN;
          end
        end
        RUN: begin
          diff_chunk_reg[index_reg] <= sub_next[CHUNK-1:0];
          chain_reg                 <= sub_next[CHUNK];
          if (index_reg == LAST_IDX) begin
            state_reg <= FINISH;
          end else begin
            index_reg <= index_reg + 1'b1;
          end
        end
        FINISH: begin
          borrow_reg <= chain_reg;
          if (cond_reg && chain_reg) begin
            for (int i = 0; i < NCHUNK; i++) begin
              diff_chunk_reg[i] <= a_chunk[i];
            end
          end
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign borrow = borrow_reg;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Scoreboard bench for chunked_subtractor: expected diff/borrow/done-cycle queued at issue,
// compared when done pulses.
module tb_chunked_subtractor;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cond_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cond;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_borrow;
    int               exp_cyc;
  } sb_t;

  sb_t sb_q[$];
  int  cyc     = 0;
  int  n_check = 0;
  int  n_pass  = 0;

  chunked_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cond_sub(cond_sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .borrow  (borrow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_check++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("diff",    64'(diff),   64'(e.exp_diff));
        check("borrow",  64'(borrow), 64'(e.exp_borrow));
        check("latency", 64'(cyc),    64'(e.exp_cyc));
        check("busy_at_done", 64'(busy), 64'(0));
        $display("op a=%08h b=%08h cond=%0d -> diff=%08h borrow=%0d cyc=%0d",
                 e.a, e.b, e.cond, diff, borrow, cyc);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic tc, input bit track);
    sb_t e;
    a        = ta;
    b        = tb_v;
    cond_sub = tc;
    start    = 1'b1;
    if (track) begin
      e.a          = ta;
      e.b          = tb_v;
      e.cond       = tc;
      e.exp_borrow = (ta < tb_v);
      e.exp_diff   = (tc && (ta < tb_v)) ? ta : ta - tb_v;
      e.exp_cyc    = cyc + 1 + NCHUNK + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    rst      = 1'b1;
    start    = 1'b0;
    cond_sub = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy",   64'(busy),   64'(0));
    check("rst_done",   64'(done),   64'(0));
    check("rst_diff",   64'(diff),   64'(0));
    check("rst_borrow", 64'(borrow), 64'(0));

    // Directed cases, including the cross-chunk borrow chain.
    issue(32'd10, 32'd3, 1'b0, 1'b1);         wait_done();
    issue(32'd3, 32'd10, 1'b0, 1'b1);         wait_done();
    issue(32'd3, 32'd10, 1'b1, 1'b1);         wait_done();
    issue(32'h0100_0000, 32'd1, 1'b0, 1'b1);  wait_done();
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1); wait_done();
    issue(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_done();

    // Second start two cycles into an operation must be dropped.
    issue(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b1);
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h1; cond_sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    // Leave a nonzero result behind, then reset in the middle of chunk 2.
    issue(32'd3, 32'd10, 1'b0, 1'b1); wait_done();
    issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",   64'(busy),   64'(0));
    check("midrst_done",   64'(done),   64'(0));
    check("midrst_diff",   64'(diff),   64'(0));
    check("midrst_borrow", 64'(borrow), 64'(0));
    repeat (8) @(negedge clk);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1); wait_done();

    // Random operations in both modes, with occasional equal operands.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 9) == 0) ? ra : WIDTH'($urandom);
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      wait_done();
    end

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
